// File: rtl/stream_inst_fetch.sv
// Instruction streamer: fetches a run of words from BRAM into a prefetch FIFO,
// decodes the opcode byte of the head word and dispatches it to one of NUM_CH channels.
module stream_inst_fetch #(
    parameter int              DATA_W      = 128,
    parameter int              ADDR_W      = 32,
    parameter int              OP_W        = 8,
    parameter int              NUM_CH      = 5,
    parameter logic [OP_W-1:0] OP_BASE     = 8'h10,
    parameter int              FIFO_DEPTH  = 4,
    parameter int              ADDR_STRIDE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [15:0]       i_inst_count,
    output logic              o_busy,
    output logic              o_finish,
    output logic              o_err_op,
    output logic [7:0]        o_err_cnt,
    output logic              o_rd_start,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_done,
    input  logic [NUM_CH-1:0] i_ch_ready,
    output logic [NUM_CH-1:0] o_ch_valid,
    output logic [DATA_W-1:0] o_ch_data
);

    localparam int              PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]  DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [OP_W-1:0] NCH_C    = OP_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(ADDR_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op >= OP_BASE) && ((op - OP_BASE) < NCH_C);
    endfunction

    function automatic logic [NUM_CH-1:0] op_onehot(input logic [OP_W-1:0] op);
        logic [NUM_CH-1:0] oh;
        oh = {{(NUM_CH-1){1'b0}}, 1'b1} << (op - OP_BASE);
        return op_legal(op) ? oh : {NUM_CH{1'b0}};
    endfunction

    state_t              r_state;
    state_t              w_state_nx;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_occ;
    logic [15:0]         r_count;
    logic [15:0]         r_fetched;
    logic [15:0]         r_disp;
    logic                r_busy;
    logic                r_finish;
    logic                r_err_op;
    logic [7:0]          r_err_cnt;
    logic                r_rd_start;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [NUM_CH-1:0]   r_ch_valid;
    logic [DATA_W-1:0]   r_ch_data;

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_head_illegal;
    logic [PTR_W-1:0]    w_rd_ptr_nx;
    logic [PTR_W:0]      w_occ_after_pop;
    logic [PTR_W:0]      w_occ_nx;
    logic [15:0]         w_fetched_nx;
    logic [15:0]         w_disp_nx;
    logic                w_all_done;
    logic [DATA_W-1:0]   w_head_nx;

    // r_ch_data always mirrors the FIFO head while r_occ is non-zero, so the
    // pop decision can be taken from the registered outputs.
    assign w_accept        = i_start && (r_state == S_IDLE);
    assign w_push          = (r_state == S_REQ) && i_rd_done;
    assign w_head_illegal  = !op_legal(r_ch_data[DATA_W-1 -: OP_W]);
    assign w_pop           = (r_occ != '0) && (w_head_illegal || ((r_ch_valid & i_ch_ready) != '0));
    assign w_rd_ptr_nx     = r_rd_ptr + PTR_W'(w_pop);
    assign w_occ_after_pop = r_occ - (PTR_W+1)'(w_pop);
    assign w_occ_nx        = w_occ_after_pop + (PTR_W+1)'(w_push);
    assign w_fetched_nx    = r_fetched + 16'(w_push);
    assign w_disp_nx       = r_disp + 16'(w_pop);
    assign w_all_done      = (w_fetched_nx == r_count) && (w_occ_nx == '0) && (w_disp_nx == r_count);
    assign w_head_nx       = (w_occ_after_pop == '0) ? i_rd_data : r_mem[w_rd_ptr_nx];

    // Fetch FSM next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = (i_inst_count == 16'd0) ? S_FIN : S_REQ;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_REQ: begin
                if (w_push) w_state_nx = S_GAP;
                else        w_state_nx = S_REQ;
            end
            S_GAP: begin
                if (w_all_done)                w_state_nx = S_FIN;
                else if (r_fetched == r_count) w_state_nx = S_DONE;
                else if (r_occ < DEPTH_C)      w_state_nx = S_REQ;
                else                           w_state_nx = S_GAP;
            end
            S_DONE: begin
                if (w_all_done) w_state_nx = S_FIN;
                else            w_state_nx = S_DONE;
            end
            S_FIN:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Prefetch storage; stale entries are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_rd_data;
    end

    // FIFO pointers, occupancy and run counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_count   <= 16'd0;
            r_fetched <= 16'd0;
            r_disp    <= 16'd0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= w_rd_ptr_nx;
            r_occ    <= w_occ_nx;
            if (w_accept) begin
                r_count   <= i_inst_count;
                r_fetched <= 16'd0;
                r_disp    <= 16'd0;
            end else begin
                r_fetched <= w_fetched_nx;
                r_disp    <= w_disp_nx;
            end
        end
    end

    // Read address and illegal-opcode bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_err_op  <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_accept)    r_rd_addr <= i_base_addr;
            else if (w_push) r_rd_addr <= r_rd_addr + STRIDE_C;
            if (w_accept) begin
                r_err_op  <= 1'b0;
                r_err_cnt <= 8'd0;
            end else if (w_pop && w_head_illegal) begin
                r_err_op  <= 1'b1;
                r_err_cnt <= (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;
            end
        end
    end

    // Status and dispatch outputs, registered from the next-cycle view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_rd_start <= 1'b0;
            r_ch_valid <= '0;
            r_ch_data  <= '0;
        end else begin
            r_busy     <= (w_state_nx != S_IDLE);
            r_finish   <= (w_state_nx == S_FIN);
            r_rd_start <= (w_state_nx == S_REQ);
            r_ch_valid <= (w_occ_nx != '0) ? op_onehot(w_head_nx[DATA_W-1 -: OP_W]) : '0;
            r_ch_data  <= (w_occ_nx != '0) ? w_head_nx : '0;
        end
    end

    assign o_busy     = r_busy;
    assign o_finish   = r_finish;
    assign o_err_op   = r_err_op;
    assign o_err_cnt  = r_err_cnt;
    assign o_rd_start = r_rd_start;
    assign o_rd_addr  = r_rd_addr;
    assign o_ch_valid = r_ch_valid;
    assign o_ch_data  = r_ch_data;

endmodule

// File: tb/tb_stream_inst_fetch.sv
// Scoreboard bench for stream_inst_fetch: a BRAM responder predicts each dispatch,
// a monitor checks every presented word against the queue of predictions.
module tb_stream_inst_fetch;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 32;
    localparam int NUM_CH = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic [15:0]       i_inst_count;
    logic              o_busy, o_finish, o_err_op, o_rd_start;
    logic [7:0]        o_err_cnt;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] i_rd_data;
    logic              i_rd_done;
    logic [NUM_CH-1:0] i_ch_ready;
    logic [NUM_CH-1:0] o_ch_valid;
    logic [DATA_W-1:0] o_ch_data;

    stream_inst_fetch dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_inst_count(i_inst_count), .o_busy(o_busy), .o_finish(o_finish),
        .o_err_op(o_err_op), .o_err_cnt(o_err_cnt), .o_rd_start(o_rd_start),
        .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .i_rd_done(i_rd_done),
        .i_ch_ready(i_ch_ready), .o_ch_valid(o_ch_valid), .o_ch_data(o_ch_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           ch;
        logic [127:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [7:0]  op_plan[$];
    logic [31:0] model_base = 32'd0;
    int          model_idx = 0;
    int          run_cnt = 0;
    int          exp_err = 0;
    bit          last_legal = 1'b0;
    int          lat_min = 1, lat_max = 1;
    int          max_reads = 1000000;
    int          illegal_pct = 0;
    bit          stray_req = 1'b0;
    bit          ready_rand = 1'b0, ready_block = 1'b0, ready_none = 1'b0;
    int          cyc = 0;
    int          last_hs_cyc = -10;
    int          fin_cnt = 0;
    int          fc0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] make_word(input logic [7:0] op);
        return {op, $urandom(), $urandom(), $urandom(), 24'($urandom())};
    endfunction

    // BRAM responder: predicts each fetched word and its dispatch channel.
    initial begin
        logic [31:0]  ea;
        logic [7:0]   op;
        logic [127:0] w;
        bit           legal;
        int           lat;
        i_rd_done = 1'b0;
        i_rd_data = '0;
        forever begin
            @(negedge clk);
            if (stray_req) begin
                @(posedge clk); #1;
                i_rd_done = 1'b1;
                i_rd_data = make_word(8'h10);
                @(posedge clk); #1;
                i_rd_done = 1'b0;
                stray_req = 1'b0;
            end else if (o_rd_start && !rst && model_idx < max_reads) begin
                ea = model_base + 32'(model_idx) * 32'd16;
                check("rd_addr", o_rd_addr, ea);
                lat = int'($urandom_range(lat_max, lat_min));
                repeat (lat) @(negedge clk);
                if (op_plan.size() > 0) op = op_plan.pop_front();
                else if (int'($urandom_range(99, 0)) < illegal_pct)
                    op = $urandom_range(1, 0) ? 8'($urandom_range(15, 0)) : 8'($urandom_range(255, 21));
                else op = 8'h10 + 8'($urandom_range(4, 0));
                legal = (op >= 8'h10) && (op <= 8'h14);
                w = make_word(op);
                @(posedge clk); #1;
                i_rd_done = 1'b1;
                i_rd_data = w;
                if (legal) exp_q.push_back('{int'(op - 8'h10), w});
                else exp_err++;
                last_legal = legal;
                model_idx++;
                @(posedge clk); #1;
                i_rd_done = 1'b0;
            end
        end
    end

    // Channel ready driver.
    initial begin
        i_ch_ready = '0;
        forever begin
            @(posedge clk); #1;
            if (ready_none)      i_ch_ready = '0;
            else if (ready_rand) i_ch_ready = NUM_CH'($urandom());
            else                 i_ch_ready = '1;
            if (ready_block) i_ch_ready[2] = 1'b0;
        end
    end

    // Monitor: compares presented words against predictions, pops on handshake.
    initial begin
        logic [4:0] oh;
        forever begin
            @(negedge clk);
            if (!rst && o_ch_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected ch_valid", o_ch_valid, 5'b00000);
                end else begin
                    oh = 5'b00001 << exp_q[0].ch;
                    check("ch_valid", o_ch_valid, oh);
                    check("ch_data", o_ch_data, exp_q[0].data);
                    if ((o_ch_valid & i_ch_ready) != '0) begin
                        void'(exp_q.pop_front());
                        last_hs_cyc = cyc;
                    end
                end
            end
            if (o_finish) fin_cnt++;
        end
    end

    task automatic start_run(input logic [31:0] base, input logic [15:0] cnt);
        model_base = base;
        model_idx  = 0;
        exp_err    = 0;
        run_cnt    = int'(cnt);
        fc0        = fin_cnt;
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = base; i_inst_count = cnt;
        @(posedge clk); #1;
        i_start = 1'b0; i_base_addr = $urandom(); i_inst_count = 16'($urandom());
        @(negedge clk);
        check("rd_start cycle 1", o_rd_start, cnt != 16'd0);
        check("busy cycle 1", o_busy, 1'b1);
        check("finish cycle 1", o_finish, cnt == 16'd0);
    endtask

    task automatic wait_finish(input string tag);
        bit got;
        int fin_cyc;
        int e_cnt;
        got = o_finish;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = o_finish;
        end
        check({tag, " finish seen"}, got, 1'b1);
        if (got) begin
            fin_cyc = cyc;
            e_cnt = (exp_err > 255) ? 255 : exp_err;
            check({tag, " queue drained"}, exp_q.size(), 0);
            check({tag, " words read"}, model_idx, run_cnt);
            check({tag, " err_cnt"}, o_err_cnt, e_cnt);
            check({tag, " err_op"}, o_err_op, exp_err > 0);
            check({tag, " busy at finish"}, o_busy, 1'b1);
            if (run_cnt > 0 && last_legal)
                check({tag, " finish after last pop"}, fin_cyc, last_hs_cyc + 1);
            @(negedge clk);
            check({tag, " busy falls"}, o_busy, 1'b0);
            check({tag, " single finish"}, fin_cnt - fc0, 1);
        end
    endtask

    initial begin
        bit ok;
        bit quiet;
        i_start = 1'b0; i_base_addr = '0; i_inst_count = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {o_busy, o_finish, o_err_op, o_err_cnt, o_rd_start, o_rd_addr, o_ch_valid}, '0);
        check("reset ch_data", o_ch_data, '0);
        @(posedge clk); #1 rst = 1'b0;

        // Three legal words to channels 0, 1, 4.
        op_plan = '{8'h10, 8'h11, 8'h14};
        start_run(32'hC000_0000, 16'd3);
        wait_finish("basic");

        // Blocked channel fills the FIFO and stalls fetching.
        op_plan = '{8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12};
        ready_block = 1'b1;
        start_run(32'h0000_1000, 16'd6);
        repeat (30) @(negedge clk);
        check("reads while blocked", model_idx, 4);
        check("rd_start while full", o_rd_start, 1'b0);
        ready_block = 1'b0;
        wait_finish("backpressure");

        // Illegal opcode in the middle.
        op_plan = '{8'h10, 8'h20, 8'h11};
        start_run(32'h0000_2000, 16'd3);
        wait_finish("illegal");

        // Address wrap.
        start_run(32'hFFFF_FFF0, 16'd2);
        wait_finish("wrap");

        // Empty run, then a start issued while busy.
        start_run(32'h0000_3000, 16'd0);
        wait_finish("empty");
        op_plan = '{8'h13, 8'h10, 8'h12};
        start_run(32'h0000_4000, 16'd3);
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = 32'h0000_9000; i_inst_count = 16'd7;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_finish("start while busy");

        // Reset during an outstanding request with two words buffered.
        ready_none = 1'b1;
        max_reads  = 2;
        start_run(32'h0000_5000, 16'd5);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = o_rd_start && (model_idx == 2);
        end
        check("third request pending", ok, 1'b1);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid-run reset outputs", {o_busy, o_finish, o_err_op, o_err_cnt, o_rd_start, o_rd_addr, o_ch_valid}, '0);
        check("mid-run reset ch_data", o_ch_data, '0);
        @(posedge clk); #1;
        rst = 1'b0; max_reads = 1000000; ready_none = 1'b0; stray_req = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_busy || o_rd_start || o_ch_valid != '0) quiet = 1'b0;
        end
        check("stray rd_done ignored", quiet, 1'b1);
        check("stray pulse issued", stray_req, 1'b0);
        start_run(32'h0000_6000, 16'd4);
        wait_finish("after reset");

        // Randomised runs: random latency, readiness and some illegal opcodes.
        ready_rand  = 1'b1;
        illegal_pct = 15;
        lat_min     = 0;
        lat_max     = 3;
        for (int r = 0; r < 8; r++) begin
            start_run($urandom(), 16'($urandom_range(12, 1)));
            wait_finish("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
